bp_stream_mmio_responder: RTL and testbench
===========================================

# bp_stream_mmio_responder

Terminates BedRock burst IO commands addressed to the host window and serializes each uncached write into an outgoing NBF-format flit stream toward the host, e.g. putchar, finish, or status writes. After the last flit of a write has left, it returns the matching IO response. It is the processor-to-host counterpart of the NBF stream loader and sits between the IO network egress and the FPGA host stream FIFO.

## Interface
Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, bedrock_data_width_p and mem header widths
- stream_data_width_p, 32, outgoing flit width
- nbf_opcode_width_p, 8, NBF opcode field width
- nbf_addr_width_p, paddr_width_p, NBF address field width
- nbf_data_width_p, dword_width_gp, NBF data field width
- nbf_num_flits_lp (local), CDIV(opcode+addr+data widths, stream_data_width_p); 4 for defaults (112 bits)

Ports:
- clk_i  in  1  single clock
- reset_i  in  1  asynchronous, active-high reset
- io_cmd_header_i  in  mem_header_width_lp  BedRock mem header
- io_cmd_header_v_i / io_cmd_header_ready_and_o  in/out  1  header handshake
- io_cmd_has_data_i  in  1  unused
- io_cmd_data_i  in  bedrock_data_width_p  command data beat
- io_cmd_data_v_i / io_cmd_data_ready_and_o  in/out  1  data handshake
- io_cmd_last_i  in  1  last data beat
- io_resp_header_o  out  mem_header_width_lp  response header
- io_resp_header_v_o / io_resp_header_ready_and_i  out/in  1  response header handshake
- io_resp_has_data_o  out  1  high for reads only
- io_resp_data_o  out  bedrock_data_width_p  response data
- io_resp_data_v_o / io_resp_data_ready_and_i  out/in  1  response data handshake
- io_resp_last_o  out  1  constant 1
- stream_data_o  out  stream_data_width_p  outgoing flit
- stream_v_o / stream_ready_i  out/in  1  valid-ready flit handshake
- busy_o  out  1  high in every state except e_ready

## Operation
- FSM states: e_ready, e_data, e_stream, e_resp_header, e_resp_data.
- e_ready: header_ready_and_o=1. On accept, latch header. Next state is e_data for uc_wr, e_resp_header for uc_rd.
- e_data: data_ready_and_o=1. Capture the low nbf_data_width_p bits of the first beat. Drop later beats until io_cmd_last_i, then go to e_stream.
- Packet is {opcode, addr, data}, with opcode in the MSBs.
  - Opcode 0x02 for size_4; 0x03 for size_8 and all other sizes.
  - For size_4, data[63:32] is zeroed.
- e_stream: drive flit[idx], least-significant flit first. idx advances on stream_v_o & stream_ready_i. On the last flit handshake, go to e_resp_header.
- e_resp_header: v_o=1. The header is the latched command header unchanged (msg_type, addr, size, payload).
  - On handshake, a write returns to e_ready.
  - On handshake, a read goes to e_resp_data.
- e_resp_data: v_o=1, data per Configuration. On handshake, return to e_ready.
- Other msg_types (cached or amo) are treated as reads.
- No stream output is produced for reads.

## Timing
- While reset_i is high, every valid and ready output is 0, and the state, idx and latched packet are cleared. This takes effect asynchronously. The first accept occurs the first edge after deassertion.
- Write latency, header accept to first stream_v_o: 2 cycles (one header cycle, one data beat). Response header is valid the cycle after the last flit handshake.
- No combinational path from any input valid or ready to any output valid or ready. All outputs are decoded from registered state only.
- The block handles one command at a time. No new header is accepted until the response completes.
- Boundary cases:
  - Stream stall: stream_ready_i low holds the flit and idx indefinitely.
  - Response backpressure: holds the response stable indefinitely.
  - Reset mid-stream: the partial packet is abandoned. The next packet starts at flit 0.
  - idx wraps to 0 only after the final flit.

## Configuration
- BP_STREAM_MMIO_RD_EN defined: a 32-bit write counter increments on each completed write response handshake and wraps at 2^32. uc_rd response data is the zero-extended count.
- BP_STREAM_MMIO_RD_EN undefined: no counter is built, and read response data is 0.
- In both cases reads receive a header and a data response.

## Structure
- The NBF packet struct, opcode constants (0x02, 0x03, 0xFE fence, 0xFF finish) and nbf_num_flits function belong in a shared bp_nbf_pkg. The NBF stream loader imports the same package.
- One natural sub-module, bp_nbf_piso: parallel-in, serial-out of nbf_num_flits_lp flits with valid-ready on both sides. It holds idx and the packet register.

## Test plan
- uc_wr size_8 addr 0x0010_3000 data 0x1122334455667788 -> flits on stream, LSB flit first:
  - 0x55667788
  - 0x11223344
  - 0x10_3000 low 32 bits
  - {0x03, addr high 8 bits}
  - then one response header with has_data=0.
- uc_wr size_4, data 0xDEADBEEF_000000AB -> data field 0x000000AB, opcode 0x02.
- stream_ready_i toggling 1-0-0-1 across a packet -> all 4 flits delivered in order with no duplicates. The response is not sent before the 4th handshake.
- uc_rd after three writes:
  - with BP_STREAM_MMIO_RD_EN, response data 3;
  - without it, response data 0;
  - zero stream flits in both cases.
- reset_i pulsed asynchronously after flit 1 -> all valids drop immediately. The next write emits 4 fresh flits starting at flit 0.
- io_resp_header_ready_and_i held low 10 cycles -> header stable, and io_cmd_header_ready_and_o stays 0 until the response is accepted.

Source files
------------

// File: rtl/bp_nbf_pkg.sv
// Shared NBF packet definitions plus the default-config BedRock header used by the host-stream blocks.
// Also used by the NBF stream loader.
package bp_nbf_pkg;

  localparam int unsigned paddr_width_gp           = 40;
  localparam int unsigned dword_width_gp           = 64;
  localparam int unsigned bedrock_data_width_gp    = 64;
  localparam int unsigned bedrock_payload_width_gp = 16;

  localparam logic [7:0] nbf_op_write4_gc = 8'h02;
  localparam logic [7:0] nbf_op_write8_gc = 8'h03;
  localparam logic [7:0] nbf_op_fence_gc  = 8'hFE;
  localparam logic [7:0] nbf_op_finish_gc = 8'hFF;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [bedrock_payload_width_gp-1:0] payload;
    logic [paddr_width_gp-1:0]           addr;
    bp_bedrock_msg_size_e                size;
    bp_bedrock_mem_type_e                msg_type;
  } bp_bedrock_mem_header_s;

  // Opcode sits in the MSBs so the first flit on the wire carries data LSBs
  typedef struct packed {
    logic [7:0]                opcode;
    logic [paddr_width_gp-1:0] addr;
    logic [dword_width_gp-1:0] data;
  } bp_nbf_s;

  typedef enum logic [2:0] {
    e_ready,
    e_data,
    e_stream,
    e_resp_header,
    e_resp_data
  } bp_stream_mmio_state_e;

  function automatic int unsigned nbf_num_flits(input int unsigned opcode_width,
                                                input int unsigned addr_width,
                                                input int unsigned data_width,
                                                input int unsigned flit_width);
    return (opcode_width + addr_width + data_width + flit_width - 1) / flit_width;
  endfunction

endpackage

// File: rtl/bp_nbf_piso.sv
// Parallel-in serial-out of one NBF packet, least-significant flit first.
module bp_nbf_piso #(
  parameter int unsigned flit_width_p = 32,
  parameter int unsigned num_flits_p  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [flit_width_p*num_flits_p-1:0] packet,
  input  logic                                packet_v,
  output logic                                packet_ready,
  output logic [flit_width_p-1:0]             flit,
  output logic                                flit_v,
  input  logic                                flit_ready,
  output logic                                done_c
);

  localparam int unsigned idx_width_lp = (num_flits_p > 1) ? $clog2(num_flits_p) : 1;
  localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(num_flits_p - 1);

  logic [flit_width_p*num_flits_p-1:0] packet_r;
  logic [idx_width_lp-1:0]             idx;
  logic                                full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      packet_r <= '0;
      idx      <= '0;
      full     <= 1'b0;
    end else if (packet_v && !full) begin
      packet_r <= packet;
      idx      <= '0;
      full     <= 1'b1;
    end else if (full && flit_ready) begin
      if (idx == last_idx_lp) begin
        idx  <= '0;
        full <= 1'b0;
      end else begin
        idx <= idx + idx_width_lp'(1);
      end
    end
  end

  assign packet_ready = ~full;
  assign flit_v       = full;
  assign flit         = packet_r[idx*flit_width_p +: flit_width_p];
  assign done_c       = full & flit_ready & (idx == last_idx_lp);

endmodule

// File: rtl/bp_stream_mmio_responder.sv
// Terminates host-window IO commands; uncached writes leave as NBF flits, then the IO response returns.
// Optional BP_STREAM_MMIO_RD_EN: reads return a count of completed writes instead of zero.
module bp_stream_mmio_responder
  import bp_nbf_pkg::*;
#(
  parameter int unsigned stream_data_width_p = 32,
  parameter int unsigned nbf_opcode_width_p  = 8,
  parameter int unsigned nbf_addr_width_p    = paddr_width_gp,
  parameter int unsigned nbf_data_width_p    = dword_width_gp
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  bp_bedrock_mem_header_s           io_cmd_header_i,
  input  logic                             io_cmd_header_v_i,
  output logic                             io_cmd_header_ready_and_o,
  input  logic                             io_cmd_has_data_i,
  input  logic [bedrock_data_width_gp-1:0] io_cmd_data_i,
  input  logic                             io_cmd_data_v_i,
  output logic                             io_cmd_data_ready_and_o,
  input  logic                             io_cmd_last_i,
  output bp_bedrock_mem_header_s           io_resp_header_o,
  output logic                             io_resp_header_v_o,
  input  logic                             io_resp_header_ready_and_i,
  output logic                             io_resp_has_data_o,
  output logic [bedrock_data_width_gp-1:0] io_resp_data_o,
  output logic                             io_resp_data_v_o,
  input  logic                             io_resp_data_ready_and_i,
  output logic                             io_resp_last_o,
  output logic [stream_data_width_p-1:0]   stream_data_o,
  output logic                             stream_v_o,
  input  logic                             stream_ready_i,
  output logic                             busy_o
);

  localparam int unsigned nbf_num_flits_lp =
    nbf_num_flits(nbf_opcode_width_p, nbf_addr_width_p, nbf_data_width_p, stream_data_width_p);
  localparam int unsigned packet_width_lp = nbf_num_flits_lp * stream_data_width_p;

  bp_stream_mmio_state_e            state;
  bp_bedrock_mem_header_s           header_r;
  logic [bedrock_data_width_gp-1:0] data_r;
  logic                             first_beat;
  logic                             is_wr, is_size4;
  logic [bedrock_data_width_gp-1:0] beat;
  logic [nbf_opcode_width_p-1:0]    nbf_opcode;
  logic [nbf_data_width_p-1:0]      nbf_data;
  logic [packet_width_lp-1:0]       packet;
  logic                             piso_load_v, piso_load_ready, piso_done;
  logic                             unused;

  assign unused = io_cmd_has_data_i;

  assign is_wr    = (header_r.msg_type == e_bedrock_mem_uc_wr);
  assign is_size4 = (header_r.size == e_bedrock_msg_size_4);

  // Single-beat commands feed the packet straight from the bus; later beats are dropped
  assign beat       = first_beat ? io_cmd_data_i : data_r;
  assign nbf_opcode = is_size4 ? nbf_opcode_width_p'(nbf_op_write4_gc)
                               : nbf_opcode_width_p'(nbf_op_write8_gc);
  assign nbf_data   = is_size4 ? nbf_data_width_p'(beat[31:0]) : nbf_data_width_p'(beat);
  assign packet     = packet_width_lp'({nbf_opcode, nbf_addr_width_p'(header_r.addr), nbf_data});

  assign piso_load_v = (state == e_data) & io_cmd_data_v_i & io_cmd_last_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= e_ready;
      header_r   <= '0;
      data_r     <= '0;
      first_beat <= 1'b0;
    end else begin
      case (state)
        e_ready:
          if (io_cmd_header_v_i) begin
            header_r   <= io_cmd_header_i;
            first_beat <= 1'b1;
            state      <= (io_cmd_header_i.msg_type == e_bedrock_mem_uc_wr) ? e_data : e_resp_header;
          end
        e_data:
          if (io_cmd_data_v_i && piso_load_ready) begin
            first_beat <= 1'b0;
            if (first_beat) data_r <= io_cmd_data_i;
            if (io_cmd_last_i) state <= e_stream;
          end
        e_stream:
          if (piso_done) state <= e_resp_header;
        e_resp_header:
          if (io_resp_header_ready_and_i) state <= is_wr ? e_ready : e_resp_data;
        e_resp_data:
          if (io_resp_data_ready_and_i) state <= e_ready;
        default:
          state <= e_ready;
      endcase
    end
  end

  bp_nbf_piso #(
    .flit_width_p(stream_data_width_p),
    .num_flits_p (nbf_num_flits_lp)
  ) piso (
    .clk         (clk_i),
    .rst         (reset_i),
    .packet      (packet),
    .packet_v    (piso_load_v),
    .packet_ready(piso_load_ready),
    .flit        (stream_data_o),
    .flit_v      (stream_v_o),
    .flit_ready  (stream_ready_i),
    .done_c      (piso_done)
  );

  // Handshake outputs depend only on registered state; reset forces them low immediately
  assign io_cmd_header_ready_and_o = ~reset_i & (state == e_ready);
  assign io_cmd_data_ready_and_o   = ~reset_i & (state == e_data) & piso_load_ready;
  assign io_resp_header_v_o        = ~reset_i & (state == e_resp_header);
  assign io_resp_data_v_o          = ~reset_i & (state == e_resp_data);
  assign io_resp_header_o          = header_r;
  assign io_resp_has_data_o        = ~is_wr;
  assign io_resp_last_o            = 1'b1;
  assign busy_o                    = (state != e_ready);

`ifdef BP_STREAM_MMIO_RD_EN
  logic [31:0] wr_count;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) wr_count <= '0;
    else if ((state == e_resp_header) && io_resp_header_ready_and_i && is_wr)
      wr_count <= wr_count + 32'd1;
  end

  assign io_resp_data_o = bedrock_data_width_gp'(wr_count);
`else
  assign io_resp_data_o = '0;
`endif

endmodule

// File: tb/tb_bp_stream_mmio_responder.sv
// Self-checking bench for bp_stream_mmio_responder: queue model of flits and responses plus literal pins.
// Honors BP_STREAM_MMIO_RD_EN for expected read data.
module tb_bp_stream_mmio_responder;
  import bp_nbf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset_i;
  bp_bedrock_mem_header_s cmd_hdr, resp_hdr;
  logic                   cmd_hdr_v, cmd_hdr_rdy, cmd_has_data;
  logic [63:0]            cmd_data, resp_data;
  logic                   cmd_data_v, cmd_data_rdy, cmd_last;
  logic                   resp_hdr_v, resp_hdr_rdy, resp_has_data;
  logic                   resp_data_v, resp_data_rdy, resp_last;
  logic [31:0]            stream_data;
  logic                   stream_v, stream_ready, busy;

  bp_stream_mmio_responder dut (
    .clk_i(clk), .reset_i(reset_i),
    .io_cmd_header_i(cmd_hdr), .io_cmd_header_v_i(cmd_hdr_v), .io_cmd_header_ready_and_o(cmd_hdr_rdy),
    .io_cmd_has_data_i(cmd_has_data), .io_cmd_data_i(cmd_data), .io_cmd_data_v_i(cmd_data_v),
    .io_cmd_data_ready_and_o(cmd_data_rdy), .io_cmd_last_i(cmd_last),
    .io_resp_header_o(resp_hdr), .io_resp_header_v_o(resp_hdr_v), .io_resp_header_ready_and_i(resp_hdr_rdy),
    .io_resp_has_data_o(resp_has_data), .io_resp_data_o(resp_data), .io_resp_data_v_o(resp_data_v),
    .io_resp_data_ready_and_i(resp_data_rdy), .io_resp_last_o(resp_last),
    .stream_data_o(stream_data), .stream_v_o(stream_v), .stream_ready_i(stream_ready), .busy_o(busy)
  );

  typedef struct {
    bp_bedrock_mem_header_s hdr;
    bit                     is_rd;
  } resp_t;

  int           n_checks = 0, n_fail = 0, flits_seen = 0;
  logic [31:0]  flit_q[$], flit_log[$];
  resp_t        resp_q[$];
  bit           rd_hdr_done = 1'b0;
  int unsigned  model_wr_count = 0;
  logic [63:0]  last_rd_data = '0;

`ifdef BP_STREAM_MMIO_RD_EN
  localparam logic [63:0] rd_after_three_lp = 64'd3;
`else
  localparam logic [63:0] rd_after_three_lp = 64'd0;
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  function automatic logic [63:0] exp_rd_data();
`ifdef BP_STREAM_MMIO_RD_EN
    return 64'(model_wr_count);
`else
    return 64'd0;
`endif
  endfunction

  function automatic bp_bedrock_mem_header_s mk(input bp_bedrock_mem_type_e t, input bp_bedrock_msg_size_e s,
                                                input logic [39:0] a, input logic [15:0] pl);
    bp_bedrock_mem_header_s h;
    h.msg_type = t; h.size = s; h.addr = a; h.payload = pl;
    return h;
  endfunction

  // Model: packet {pad, opcode, addr, data}, sliced LSB-first into 32-bit flits
  task automatic push_write(input bp_bedrock_mem_header_s h, input logic [63:0] d);
    logic [127:0] p;
    logic [7:0]   op;
    logic [63:0]  dd;
    resp_t        r;
    op = (h.size == e_bedrock_msg_size_4) ? 8'h02 : 8'h03;
    dd = (h.size == e_bedrock_msg_size_4) ? {32'h0, d[31:0]} : d;
    p  = {16'h0, op, h.addr, dd};
    for (int i = 0; i < 4; i++) flit_q.push_back(p[32*i +: 32]);
    r.hdr = h; r.is_rd = 1'b0;
    resp_q.push_back(r);
  endtask

  task automatic push_read(input bp_bedrock_mem_header_s h);
    resp_t r;
    r.hdr = h; r.is_rd = 1'b1;
    resp_q.push_back(r);
  endtask

  // Drivers start and return at posedge+1
  task automatic send_hdr(input bp_bedrock_mem_header_s h);
    int n = 0;
    cmd_hdr = h; cmd_hdr_v = 1'b1;
    @(negedge clk);
    while (!cmd_hdr_rdy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) flag("hdr_accept_timeout");
    @(posedge clk); #1 cmd_hdr_v = 1'b0;
  endtask

  task automatic send_data(input logic [63:0] d, input logic last);
    int n = 0;
    cmd_data = d; cmd_last = last; cmd_data_v = 1'b1; cmd_has_data = 1'b1;
    @(negedge clk);
    while (!cmd_data_rdy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) flag("data_accept_timeout");
    @(posedge clk); #1 cmd_data_v = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); #1; n++; end
    while ((flit_q.size() != 0 || resp_q.size() != 0) && n < 200);
    if (n >= 200) flag(name);
    @(posedge clk); #1;
  endtask

  // Compare process: every negedge, outputs checked against the model queues
  always @(negedge clk) begin
    if (reset_i) begin
      chk("reset_outputs", {cmd_hdr_rdy, cmd_data_rdy, resp_hdr_v, resp_data_v, stream_v, busy}, '0);
      flit_q.delete(); resp_q.delete(); rd_hdr_done = 1'b0; model_wr_count = 0;
    end else begin
      if (stream_v) begin
        if (flit_q.size() == 0) flag("unexpected_flit");
        else begin
          chk("flit", stream_data, flit_q[0]);
          if (stream_ready) begin
            flit_log.push_back(flit_q.pop_front());
            flits_seen++;
          end
        end
      end
      if (resp_hdr_v) begin
        chk("resp_before_last_flit", flit_q.size(), 0);
        chk("cmd_ready_while_resp", cmd_hdr_rdy, 0);
        if (resp_q.size() == 0) flag("unexpected_resp_header");
        else begin
          chk("resp_header", resp_hdr, resp_q[0].hdr);
          chk("resp_has_data", resp_has_data, resp_q[0].is_rd);
          if (resp_hdr_rdy) begin
            if (resp_q[0].is_rd) rd_hdr_done = 1'b1;
            else begin void'(resp_q.pop_front()); model_wr_count++; end
          end
        end
      end
      if (resp_data_v) begin
        if (resp_q.size() == 0 || !resp_q[0].is_rd || !rd_hdr_done) flag("unexpected_resp_data");
        else begin
          chk("resp_data", resp_data, exp_rd_data());
          chk("resp_last", resp_last, 1);
          if (resp_data_rdy) begin
            last_rd_data = resp_data;
            void'(resp_q.pop_front());
            rd_hdr_done = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    bp_bedrock_mem_header_s h;
    int fs, n;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    reset_i = 1'b1; cmd_hdr = '0; cmd_hdr_v = 1'b0; cmd_has_data = 1'b0; cmd_data = '0;
    cmd_data_v = 1'b0; cmd_last = 1'b0; resp_hdr_rdy = 1'b1; resp_data_rdy = 1'b1; stream_ready = 1'b1;
    #1 chk("reset_hdr_ready", cmd_hdr_rdy, 0);

    // size_8 write, header already valid when reset drops
    h = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h00_0010_3000, 16'h00A1);
    cmd_hdr = h; cmd_hdr_v = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_i = 1'b0;
    push_write(h, 64'h1122_3344_5566_7788);
    @(posedge clk); #1 cmd_hdr_v = 1'b0;
    chk("first_edge_accept", busy, 1);
    chk("stream_v_after_hdr", stream_v, 0);
    chk("data_ready_after_hdr", cmd_data_rdy, 1);
    flit_log.delete();
    send_data(64'h1122_3344_5566_7788, 1'b1);
    chk("stream_v_after_data", stream_v, 1);
    wait_idle("idle_timeout_wr8");
    chk("wr8_nflits", flit_log.size(), 4);
    chk("wr8_flit0", flit_log[0], 32'h5566_7788);
    chk("wr8_flit1", flit_log[1], 32'h1122_3344);
    chk("wr8_flit2", flit_log[2], 32'h0010_3000);
    chk("wr8_flit3", flit_log[3], 32'h0000_0300);

    // size_4 write, two beats; second beat must be dropped
    h = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_4, 40'h00_0010_3008, 16'h00B2);
    push_write(h, 64'hDEAD_BEEF_0000_00AB);
    flit_log.delete();
    send_hdr(h);
    send_data(64'hDEAD_BEEF_0000_00AB, 1'b0);
    send_data(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_idle("idle_timeout_wr4");
    chk("wr4_flit0", flit_log[0], 32'h0000_00AB);
    chk("wr4_flit1", flit_log[1], 32'h0000_0000);
    chk("wr4_flit2", flit_log[2], 32'h0010_3008);
    chk("wr4_flit3", flit_log[3], 32'h0000_0200);

    // stream_ready toggling 1-0-0-1
    h = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h00_0010_3010, 16'h00C3);
    push_write(h, 64'hCAFE_F00D_1234_5678);
    flit_log.delete();
    fs = flits_seen;
    send_hdr(h);
    send_data(64'hCAFE_F00D_1234_5678, 1'b1);
    for (int k = 0; k < 40 && flit_q.size() > 0; k++) begin
      stream_ready = pat[k % 4];
      @(posedge clk); #1;
    end
    stream_ready = 1'b1;
    wait_idle("idle_timeout_toggle");
    chk("toggle_nflits", flits_seen - fs, 4);
    chk("toggle_flit0", flit_log[0], 32'h1234_5678);
    chk("toggle_flit3", flit_log[3], 32'h0000_0300);

    // uc_rd after three writes
    h = mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, 40'h00_0010_3018, 16'h00D4);
    push_read(h);
    fs = flits_seen;
    send_hdr(h);
    wait_idle("idle_timeout_rd");
    chk("rd_no_flits", flits_seen - fs, 0);
    chk("rd_data_after_3_writes", last_rd_data, rd_after_three_lp);

    // reset after flit 1, then a fresh packet
    h = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h00_0010_3020, 16'h00E5);
    push_write(h, 64'h0123_4567_89AB_CDEF);
    fs = flits_seen;
    send_hdr(h);
    send_data(64'h0123_4567_89AB_CDEF, 1'b1);
    n = 0;
    while (flits_seen < fs + 2 && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) flag("midstream_flit_timeout");
    @(posedge clk); #1 stream_ready = 1'b0;
    #1 reset_i = 1'b1;
    #1 chk("async_reset_valids", {stream_v, resp_hdr_v, resp_data_v, cmd_hdr_rdy, cmd_data_rdy, busy}, '0);
    repeat (2) @(posedge clk);
    #2 reset_i = 1'b0; stream_ready = 1'b1;
    @(posedge clk); #1;
    h = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h00_0010_3028, 16'h00F6);
    push_write(h, 64'hA5A5_5A5A_0F0F_F0F0);
    flit_log.delete();
    fs = flits_seen;
    send_hdr(h);
    send_data(64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
    wait_idle("idle_timeout_post_reset");
    chk("post_reset_nflits", flits_seen - fs, 4);
    chk("post_reset_flit0", flit_log[0], 32'h0F0F_F0F0);

    // response header backpressure for 10 cycles
    resp_hdr_rdy = 1'b0;
    h = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h00_0010_3030, 16'h0107);
    push_write(h, 64'h0000_0000_0000_0042);
    send_hdr(h);
    send_data(64'h0000_0000_0000_0042, 1'b1);
    n = 0;
    while (!resp_hdr_v && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) flag("resp_hdr_timeout");
    for (int k = 0; k < 10; k++) begin
      chk("hold_resp_v", resp_hdr_v, 1);
      chk("hold_cmd_ready", cmd_hdr_rdy, 0);
      @(negedge clk); #1;
    end
    @(posedge clk); #1 resp_hdr_rdy = 1'b1;
    wait_idle("idle_timeout_backpressure");
    chk("ready_after_resp", cmd_hdr_rdy, 1);

    // amo is handled as a read
    h = mk(e_bedrock_mem_amo, e_bedrock_msg_size_8, 40'h00_0010_3038, 16'h0118);
    push_read(h);
    fs = flits_seen;
    send_hdr(h);
    wait_idle("idle_timeout_amo");
    chk("amo_no_flits", flits_seen - fs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
